// File: rtl/pwm_carrier_gen_pkg.sv
// rtl/pwm_carrier_gen_pkg.sv - shared PWM carrier types, default widths and mask helpers
package pwm_carrier_gen_pkg;

    localparam int PWMCOUNT_WIDTH_DEF = 16;
    localparam int DIVCLK_WIDTH_DEF   = 4;
    localparam int EVTCOUNT_WIDTH_DEF = 3;

    typedef enum logic [1:0] {COUNT_UP, COUNT_DOWN, COUNT_UPDOWN} _count_mode;
    typedef enum logic [1:0] {NO_MASK, MIN_MASK, MAX_MASK, MINMAX_MASK} _mask_mode;
    typedef enum logic {CARR_OFF, CARR_ON} _carr_onoff;
    typedef enum logic {CLKDIV_OFF, CLKDIV_ON} _clkdiv_onoff;
    typedef enum logic {INT_OFF, INT_ON} _int_onoff;
    typedef enum logic {CARR_IDLE, CARR_RUN} _carr_state;

    function automatic logic counts_min(input _mask_mode m);
        return (m == NO_MASK) || (m == MAX_MASK);
    endfunction

    function automatic logic counts_max(input _mask_mode m);
        return (m == NO_MASK) || (m == MIN_MASK);
    endfunction

endpackage

// File: rtl/pwm_carrier_gen_clkdiv.sv
// rtl/pwm_carrier_gen_clkdiv.sv - prescaler producing one tick every div+1 cycles
module pwm_clkdiv #(
    parameter int DIVCLK_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [DIVCLK_WIDTH-1:0] div,
    input  logic                    clr,
    output logic                    tick
);

    localparam logic [DIVCLK_WIDTH-1:0] DIV_ONE = DIVCLK_WIDTH'(1);

    logic [DIVCLK_WIDTH-1:0] cnt_q;
    logic                    at_div;

    assign at_div = (cnt_q == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr || !en || at_div) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_ONE;
        end
    end

    // No tick while cleared so the first update after start lands div+1 cycles later
    assign tick = !clr && (!en || at_div);

endmodule

// File: rtl/pwm_carrier_gen.sv
// rtl/pwm_carrier_gen.sv - prescaled up/down/updown PWM carrier with shadowed period and decimated irq
module pwm_carrier_gen
    import pwm_carrier_gen_pkg::*;
#(
    parameter int PWMCOUNT_WIDTH = PWMCOUNT_WIDTH_DEF,
    parameter int DIVCLK_WIDTH   = DIVCLK_WIDTH_DEF,
    parameter int EVTCOUNT_WIDTH = EVTCOUNT_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  _carr_onoff                carr_onoff,
    input  _count_mode                count_mode,
    input  _mask_mode                 mask_mode,
    input  _clkdiv_onoff              clkdiv_onoff,
    input  logic [DIVCLK_WIDTH-1:0]   clkdiv,
    input  logic [PWMCOUNT_WIDTH-1:0] period,
    input  logic [PWMCOUNT_WIDTH-1:0] init_val,
    input  _int_onoff                 int_onoff,
    input  logic [EVTCOUNT_WIDTH-1:0] evt_count,
    output logic [PWMCOUNT_WIDTH-1:0] carrier,
    output logic                      dir,
    output logic                      min_evt,
    output logic                      max_evt,
    output logic                      load_evt,
    output logic                      irq
);

    localparam logic [PWMCOUNT_WIDTH-1:0] CNT_ONE = PWMCOUNT_WIDTH'(1);
    localparam logic [EVTCOUNT_WIDTH-1:0] EVT_ONE = EVTCOUNT_WIDTH'(1);

    _carr_state                state_q, state_d;
    logic [PWMCOUNT_WIDTH-1:0] carrier_q, carrier_d, per_q, per_d;
    _count_mode                mode_q, mode_d;
    _mask_mode                 mask_q, mask_d;
    logic [EVTCOUNT_WIDTH-1:0] evt_cnt_q, evt_cnt_d;
    logic                      dir_q, dir_d;
    logic                      min_q, min_d, max_q, max_d, load_q, load_d, irq_q, irq_d;
    logic                      tick;

    logic [PWMCOUNT_WIDTH-1:0] nxt, per_eff;
    logic                      wrap, going_down, counted;

    pwm_clkdiv #(.DIVCLK_WIDTH(DIVCLK_WIDTH)) u_clkdiv (
        .clk  (clk),
        .rst  (rst),
        .en   (clkdiv_onoff == CLKDIV_ON),
        .div  (clkdiv),
        .clr  (state_q == CARR_IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CARR_IDLE;
            carrier_q <= '0;
            per_q     <= '0;
            mode_q    <= COUNT_UP;
            mask_q    <= NO_MASK;
            evt_cnt_q <= '0;
            dir_q     <= 1'b0;
            min_q     <= 1'b0;
            max_q     <= 1'b0;
            load_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            carrier_q <= carrier_d;
            per_q     <= per_d;
            mode_q    <= mode_d;
            mask_q    <= mask_d;
            evt_cnt_q <= evt_cnt_d;
            dir_q     <= dir_d;
            min_q     <= min_d;
            max_q     <= max_d;
            load_q    <= load_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        carrier_d  = carrier_q;
        per_d      = per_q;
        mode_d     = mode_q;
        mask_d     = mask_q;
        evt_cnt_d  = evt_cnt_q;
        dir_d      = dir_q;
        min_d      = 1'b0;
        max_d      = 1'b0;
        load_d     = 1'b0;
        irq_d      = 1'b0;
        nxt        = carrier_q;
        per_eff    = per_q;
        wrap       = 1'b0;
        going_down = 1'b0;
        counted    = 1'b0;

        case (state_q)
            CARR_IDLE: begin
                carrier_d = '0;
                dir_d     = 1'b0;
                evt_cnt_d = '0;
                if (carr_onoff == CARR_ON) begin
                    state_d   = CARR_RUN;
                    per_d     = period;
                    mode_d    = count_mode;
                    mask_d    = mask_mode;
                    carrier_d = (init_val > period) ? period : init_val;
                    dir_d     = (count_mode == COUNT_DOWN);
                    load_d    = 1'b1;
                end
            end
            default: begin
                if (carr_onoff == CARR_OFF) begin
                    state_d   = CARR_IDLE;
                    carrier_d = '0;
                    dir_d     = 1'b0;
                    evt_cnt_d = '0;
                end else begin
                    if (tick) begin
                        case (mode_q)
                            COUNT_DOWN: begin
                                if (carrier_q == '0) begin
                                    nxt  = period;
                                    wrap = 1'b1;
                                end else begin
                                    nxt = carrier_q - CNT_ONE;
                                end
                            end
                            COUNT_UPDOWN: begin
                                if (per_q == '0) begin
                                    nxt  = '0;
                                    wrap = 1'b1;
                                end else if (!dir_q && carrier_q < per_q) begin
                                    nxt = carrier_q + CNT_ONE;
                                end else begin
                                    going_down = 1'b1;
                                    nxt        = (carrier_q <= CNT_ONE) ? '0 : carrier_q - CNT_ONE;
                                    wrap       = (carrier_q <= CNT_ONE);
                                end
                            end
                            default: begin
                                if (carrier_q >= per_q) begin
                                    nxt  = '0;
                                    wrap = 1'b1;
                                end else begin
                                    nxt = carrier_q + CNT_ONE;
                                end
                            end
                        endcase

                        // At a wrap the boundary is judged against the freshly loaded period
                        per_eff   = wrap ? period : per_q;
                        carrier_d = nxt;
                        min_d     = (nxt == '0);
                        max_d     = (nxt == per_eff);
                        load_d    = wrap;

                        if (wrap) begin
                            per_d  = period;
                            mode_d = count_mode;
                            mask_d = mask_mode;
                            dir_d  = (count_mode == COUNT_DOWN);
                        end else if (mode_q == COUNT_DOWN) begin
                            dir_d = 1'b1;
                        end else if (mode_q == COUNT_UPDOWN) begin
                            dir_d = going_down || (nxt == per_q);
                        end else begin
                            dir_d = 1'b0;
                        end

                        counted = (min_d && counts_min(mask_q)) || (max_d && counts_max(mask_q));
                        if (counted && int_onoff == INT_ON) begin
                            if (evt_cnt_q >= evt_count) begin
                                irq_d     = 1'b1;
                                evt_cnt_d = '0;
                            end else begin
                                evt_cnt_d = evt_cnt_q + EVT_ONE;
                            end
                        end
                    end
                    if (int_onoff == INT_OFF) begin
                        evt_cnt_d = '0;
                    end
                end
            end
        endcase
    end

    assign carrier  = carrier_q;
    assign dir      = dir_q;
    assign min_evt  = min_q;
    assign max_evt  = max_q;
    assign load_evt = load_q;
    assign irq      = irq_q;

endmodule
